// File: rtl/opcode_dispatcher.sv
// opcode_dispatcher: age-ordered opcode buffer issuing to Controller with per-target and per-ID ordering
module opcode_dispatcher #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [7:0] req_opcode,
  output logic       req_ready,
  input  logic [2:0] cmp_valid,
  output logic       en,
  output logic [7:0] opcode,
  output logic [2:0] busy,
  output logic [3:0] count,
  output logic       drop_err
);
  logic [7:1] mem_q [DEPTH];
  logic [7:1] mem_d [DEPTH];
  logic [3:0] count_q, count_d;
  logic [2:0] busy_q, busy_d;
  logic [3:0] out_id_q [3];
  logic [3:0] out_id_d [3];
  logic       en_q, en_d;
  logic [7:0] opcode_q, opcode_d;
  logic       drop_err_q, drop_err_d;
  logic [DEPTH-1:0] elig;
  logic [3:0] busy_tgt;
  logic       accept;
  logic       sel_found;
  int         sel_idx;
  logic [7:1] sel_op;
  logic [1:0] sel_k;
  logic [3:0] cnt_rm;
  logic       unused;
  assign unused    = req_opcode[0];
  assign busy_tgt  = {busy_q, 1'b0};
  assign req_ready = !rst && (int'(count_q) < DEPTH);
  assign accept    = req_valid && req_ready;
  assign sel_k     = sel_op[3:2] - 2'd1;
  // entry is eligible when its target is free, its ID is not outstanding and no older entry shares its ID
  always_comb begin
    elig = '0;
    for (int i = 0; i < DEPTH; i++) begin
      elig[i] = (i < int'(count_q)) && !busy_tgt[mem_q[i][3:2]];
      for (int k = 0; k < 3; k++)
        if (busy_q[k] && out_id_q[k] == mem_q[i][7:4]) elig[i] = 1'b0;
      for (int j = 0; j < i; j++)
        if (mem_q[j][7:4] == mem_q[i][7:4]) elig[i] = 1'b0;
    end
  end
  // pick the oldest eligible entry
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = 0;
    sel_op    = '0;
    for (int i = 0; i < DEPTH; i++)
      if (!sel_found && elig[i]) begin
        sel_found = 1'b1;
        sel_idx   = i;
        sel_op    = mem_q[i];
      end
  end
  // remove the issued entry, append the accepted one, and track completions
  always_comb begin
    mem_d      = mem_q;
    busy_d     = busy_q & ~cmp_valid;
    out_id_d   = out_id_q;
    en_d       = sel_found;
    opcode_d   = sel_found ? {sel_op, 1'b1} : opcode_q;
    drop_err_d = accept && req_opcode[3:2] == 2'b00;
    cnt_rm     = sel_found ? count_q - 4'd1 : count_q;
    if (sel_found) begin
      busy_d[sel_k]   = 1'b1;
      out_id_d[sel_k] = sel_op[7:4];
      for (int i = 0; i < DEPTH - 1; i++)
        if (i >= sel_idx) mem_d[i] = mem_q[i+1];
      mem_d[DEPTH-1] = '0;
    end
    count_d = cnt_rm;
    if (accept && req_opcode[3:2] != 2'b00) begin
      for (int i = 0; i < DEPTH; i++)
        if (i == int'(cnt_rm)) mem_d[i] = req_opcode[7:1];
      count_d = cnt_rm + 4'd1;
    end
  end
  // state registers; reset aborts all queued and outstanding work
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q      <= '{default: '0};
      count_q    <= '0;
      busy_q     <= '0;
      out_id_q   <= '{default: '0};
      en_q       <= 1'b0;
      opcode_q   <= '0;
      drop_err_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      out_id_q   <= out_id_d;
      en_q       <= en_d;
      opcode_q   <= opcode_d;
      drop_err_q <= drop_err_d;
    end
  end
  assign en       = en_q;
  assign opcode   = opcode_q;
  assign busy     = busy_q;
  assign count    = count_q;
  assign drop_err = drop_err_q;
endmodule

// File: doc/opcode_dispatcher.md
# opcode_dispatcher

- Buffers transaction opcodes from the system sequencer and issues them one at a time to the `Controller` through its `en`/`opcode` inputs.
- Issue rules:
  - At most one transaction outstanding per target slave (ALU, MEM, IO).
  - Transactions that share an ID are issued strictly in order.
  - Transactions with different IDs may overtake each other.
- Sits directly upstream of `Controller`. Completion pulses derived from each slave's B/R handshake release targets.

## Interface
- `DEPTH`, default 8: number of buffer entries; must be 2..15.
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: sequencer presents a request.
- `req_opcode` in 8: opcode fields:
  - [7:4] ID.
  - [3:2] target: 01 ALU, 10 MEM, 11 IO.
  - [1] R=0 / W=1.
  - [0] ignored on input.
- `req_ready` out 1: buffer can accept, equal to (count < DEPTH); 0 while `rst` is high.
- `cmp_valid` in 3: one-cycle completion pulses: bit0 ALU, bit1 MEM, bit2 IO.
- `en` out 1: one-cycle issue strobe to `Controller`.
- `opcode` out 8: issued opcode, with bit[0] forced to 1 (running); held until the next issue.
- `busy` out 3: per-target outstanding flags, same bit order as `cmp_valid`.
- `count` out 4: occupied buffer entries.
- `drop_err` out 1: one-cycle pulse when a request with target 00 is accepted and discarded.

## Operation
- **Buffer**
  - Age-ordered compacting array; entry 0 is the oldest.
  - An accept (`req_valid & req_ready`) with target ≠ 00 appends at index `count`.
  - Target 00 is accepted but not stored, and `drop_err` pulses the next cycle.
- **Eligibility** of entry i, evaluated on registered state, all conditions required:
  - `busy[target]` == 0.
  - No busy target's recorded outstanding ID equals entry ID.
  - No entry j < i has the same ID.
- **Issue**
  - Each cycle, the lowest-index eligible entry is selected; if none, nothing issues.
  - On selection: `en`=1 next cycle, `opcode`={entry[7:1],1}, `busy[target]`←1, `out_id[target]`←ID.
  - The entry is removed, and entries above it shift down by one.
- **Completion**
  - `cmp_valid[k]` clears `busy[k]` at the next edge.
  - A pulse on a non-busy target is ignored.
  - The state update happens at the edge, so a target completing in cycle N can be issued to again in cycle N+1 at the earliest (en in N+2).
- **Simultaneous accept and issue in one cycle**
  - Removal and append both apply; `count` is unchanged.
  - The new entry lands at index `count`−1.
- **Full buffer**: `req_ready`=0, and issue continues normally. Accept when full is impossible, because `req_ready` is combinational from `count`.
- **Reset**
  - `en`=0, `opcode`=0, `busy`=0, `count`=0, `drop_err`=0.
  - The buffer and out_id are cleared, aborting any queued or outstanding work.
  - Completions arriving after reset are ignored because `busy`=0.

## Timing
- Accept at edge N: the entry is eligible for selection in cycle N+1, with `en` high in cycle N+2 (one cycle after it is visible in `count`).
- Maximum issue rate is one per cycle; three consecutive issues are possible only to three distinct free targets.
- `en` is registered and high exactly one cycle per issue. It is never asserted for a target whose `busy` bit was set at the start of the selecting cycle.
- `count` updates at the same edge as accept/issue; `busy` updates at the edge following issue selection (same edge `en` rises).

## Test plan
1. **Reset and empty.** Hold `rst` for 2 cycles then release, with no requests.
   - Required: all outputs 0; `req_ready`=0 during reset, 1 afterwards.
   - Required: `en` never asserts.
2. **Back-to-back distinct targets.** Push 0x46 (W ALU ID4) then 0x58 (R MEM ID5) on consecutive cycles.
   - Required: `en` with `opcode` 0x47, then `en` with 0x59 on the next cycle.
   - Required: `busy`=3'b011.
3. **Same-target blocking.** After scenario 2, push 0x38 (R MEM ID3).
   - Required: no issue until `cmp_valid`=3'b010 pulses.
   - Required: 0x39 issues exactly 2 cycles after that pulse.
4. **Per-ID ordering and overtaking.** With `busy`=0, push 0x36 (W ALU ID3), 0x48 (R MEM ID4), 0x4E (W IO ID4), 0x34 (R ALU ID3).
   - Required: 0x37 and 0x49 issue.
   - Required: 0x4E waits for the MEM completion even though IO is free.
   - Required: 0x34 waits for the ALU completion.
   - Required: the final issue order is 0x37, 0x49, then 0x4F/0x35 following their completions.
5. **Full buffer and simultaneous push/issue.** Fill 8 entries all targeting ALU while ALU is busy.
   - Required: `count`=8 and `req_ready`=0.
   - Pulse `cmp_valid[0]`. Required: `count`=7.
   - Push during the cycle the next entry issues. Required: `count` stays 7.
6. **Invalid target and mid-operation reset.**
   - Push 0x42. Required: `drop_err` pulses once; `count` is unchanged.
   - Assert `rst` with 3 queued and 2 busy. Required: everything clears next cycle.
   - A late `cmp_valid` pulse then produces no change.
